// File: rtl/mtr_pwm_drv.sv
// Dual-channel H-bridge PWM driver: shared 2048-clk period counter, period-boundary
// duty shadowing, and per-motor non-overlap FSM producing complementary fwd/rev drive.
module mtr_pwm_drv #(
    parameter int NONOVERLAP = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [10:0] lft_spd,
    input  logic signed [10:0] rght_spd,
    output logic               lft_fwd,
    output logic               lft_rev,
    output logic               rght_fwd,
    output logic               rght_rev,
    output logic               period_strt
);

    localparam logic [1:0]  ST_FWD    = 2'd0;
    localparam logic [1:0]  ST_REV    = 2'd1;
    localparam logic [1:0]  ST_DEAD   = 2'd2;
    localparam logic [7:0]  DCNT_LAST = 8'(NONOVERLAP - 1);
    localparam logic [10:0] CNT_LAST  = 11'h7FF;
    localparam logic [10:0] DUTY_RST  = 11'h400;

    logic [10:0] cnt_q, cnt_d;
    logic        period_end;
    logic [10:0] spd_in [2];
    logic [1:0]  fwd_o, rev_o;

    always_comb begin
        cnt_d = cnt_q + 11'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign period_strt = (cnt_q == 11'd0);
    assign period_end  = (cnt_q == CNT_LAST);

    assign spd_in[0] = lft_spd;
    assign spd_in[1] = rght_spd;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ch
            logic [10:0] duty_q, duty_d;
            logic        raw;
            logic [1:0]  state_q, state_d;
            logic        tgt_q, tgt_d;
            logic [7:0]  dcnt_q, dcnt_d;

            // Offset-binary conversion: flipping the sign bit adds 0x400.
            always_comb begin
                duty_d = duty_q;
                if (period_end) duty_d = {~spd_in[gi][10], spd_in[gi][9:0]};
            end

            assign raw = (cnt_q < duty_q);

            always_comb begin
                state_d = state_q;
                tgt_d   = tgt_q;
                dcnt_d  = dcnt_q;
                case (state_q)
                    ST_FWD: begin
                        if (!raw) begin
                            state_d = ST_DEAD;
                            tgt_d   = 1'b0;
                            dcnt_d  = '0;
                        end
                    end
                    ST_REV: begin
                        if (raw) begin
                            state_d = ST_DEAD;
                            tgt_d   = 1'b1;
                            dcnt_d  = '0;
                        end
                    end
                    default: begin
                        // Unused encoding falls here too, so it behaves as dead time.
                        if (raw != tgt_q) begin
                            tgt_d  = raw;
                            dcnt_d = '0;
                        end else if (dcnt_q == DCNT_LAST) begin
                            state_d = tgt_q ? ST_FWD : ST_REV;
                        end else begin
                            dcnt_d = dcnt_q + 8'd1;
                        end
                    end
                endcase
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    duty_q  <= DUTY_RST;
                    state_q <= ST_DEAD;
                    tgt_q   <= 1'b0;
                    dcnt_q  <= '0;
                end else begin
                    duty_q  <= duty_d;
                    state_q <= state_d;
                    tgt_q   <= tgt_d;
                    dcnt_q  <= dcnt_d;
                end
            end

            assign fwd_o[gi] = (state_q == ST_FWD);
            assign rev_o[gi] = (state_q == ST_REV);
        end
    endgenerate

    assign lft_fwd  = fwd_o[0];
    assign lft_rev  = rev_o[0];
    assign rght_fwd = fwd_o[1];
    assign rght_rev = rev_o[1];

endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Self-checking bench for mtr_pwm_drv: run-length reference model checked every cycle,
// plus per-period measurements compared against hand-computed duty/dead-time figures.
module tb_mtr_pwm_drv;

    localparam int N = 32;

    logic               clk;
    logic               rst_n;
    logic signed [10:0] lft_spd;
    logic signed [10:0] rght_spd;
    logic               lft_fwd, lft_rev, rght_fwd, rght_rev, period_strt;

    int n_cmp = 0;
    int n_bad = 0;

    mtr_pwm_drv #(.NONOVERLAP(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lft_spd    (lft_spd),
        .rght_spd   (rght_spd),
        .lft_fwd    (lft_fwd),
        .lft_rev    (lft_rev),
        .rght_fwd   (rght_fwd),
        .rght_rev   (rght_rev),
        .period_strt(period_strt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an output is on once raw has held its level for N+1 consecutive cycles.
    int m_cnt;
    int m_duty [2];
    bit run_val [2];
    int run_len [2];
    bit e_fwd [2];
    bit e_rev [2];
    int last_act [2];
    int lowrun [2];

    always @(negedge clk) begin
        bit f, r, raw;
        int act;
        if (!rst_n) begin
            chk("rst_outputs", int'({lft_fwd, lft_rev, rght_fwd, rght_rev}), 0);
            m_cnt = 0;
            for (int c = 0; c < 2; c++) begin
                m_duty[c] = 1024; run_len[c] = 0; run_val[c] = 1'b0;
                e_fwd[c] = 1'b0; e_rev[c] = 1'b0; last_act[c] = 0; lowrun[c] = 0;
            end
        end else begin
            chk("period_strt", int'(period_strt), int'(m_cnt == 0));
            for (int c = 0; c < 2; c++) begin
                f = (c == 0) ? lft_fwd : rght_fwd;
                r = (c == 0) ? lft_rev : rght_rev;
                chk(c == 0 ? "lft_fwd" : "rght_fwd", int'(f), int'(e_fwd[c]));
                chk(c == 0 ? "lft_rev" : "rght_rev", int'(r), int'(e_rev[c]));
                chk("no_overlap", int'(f & r), 0);
                act = f ? 1 : (r ? 2 : 0);
                if (act != 0) begin
                    if (last_act[c] != 0 && act != last_act[c])
                        chk("deadtime_ge_N", int'(lowrun[c] >= N), 1);
                    last_act[c] = act;
                    lowrun[c] = 0;
                end else begin
                    lowrun[c]++;
                end
                raw = (m_cnt < m_duty[c]);
                if (run_len[c] > 0 && raw == run_val[c]) begin
                    if (run_len[c] < 100000) run_len[c]++;
                end else begin
                    run_val[c] = raw;
                    run_len[c] = 1;
                end
                e_fwd[c] = run_val[c] && (run_len[c] >= N + 1);
                e_rev[c] = !run_val[c] && (run_len[c] >= N + 1);
            end
            if (m_cnt == 2047) begin
                m_duty[0] = int'(lft_spd) + 1024;
                m_duty[1] = int'(rght_spd) + 1024;
            end
            m_cnt = (m_cnt + 1) % 2048;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_spd(input int l, input int r);
        @(posedge clk);
        #2;
        lft_spd  = 11'(l);
        rght_spd = 11'(r);
    endtask

    task automatic wait_pstrt();
        int k;
        for (k = 0; k < 4100; k++) begin
            @(negedge clk);
            if (period_strt) break;
        end
        if (k >= 4100) chk("pstrt_timeout", 0, 1);
    endtask

    // Measures one whole period from cnt==0; optionally changes lft_spd at index chg_at.
    task automatic measure(input int ch, input int chg_at, input int chg_val,
                           output int nf, output int nr, output int ff, output int lf,
                           output int nps);
        bit f, r;
        nf = 0; nr = 0; ff = -1; lf = -1; nps = 0;
        wait_pstrt();
        for (int i = 0; i < 2048; i++) begin
            if (i > 0) @(negedge clk);
            f = (ch == 0) ? lft_fwd : rght_fwd;
            r = (ch == 0) ? lft_rev : rght_rev;
            if (f) begin
                nf++;
                if (ff < 0) ff = i;
                lf = i;
            end
            if (r) nr++;
            if (period_strt) nps++;
            if (i == chg_at) lft_spd = 11'(chg_val);
        end
        $display("period ch%0d: fwd=%0d rev=%0d first_fwd=%0d last_fwd=%0d pstrt=%0d",
                 ch, nf, nr, ff, lf, nps);
    endtask

    function automatic int rand_spd();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 2047)) - 1024;
            1:       return -1024 + int'($urandom_range(0, 40));
            2:       return 1023 - int'($urandom_range(0, 40));
            default: return 0;
        endcase
    endfunction

    initial begin
        int nf, nr, ff, lf, nps, k;
        bit ps0;
        rst_n = 1'b0;
        lft_spd = '0;
        rght_spd = '0;
        tick(3);
        rst_n = 1'b1;

        // Reset period at spd 0: rev misses cnt 0 since the FSM starts in dead time.
        measure(0, -1, 0, nf, nr, ff, lf, nps);
        chk("t1_rst_fwd_cnt", nf, 992);
        chk("t1_rst_first_fwd", ff, 33);
        chk("t1_rst_rev_cnt", nr, 991);
        measure(0, -1, 0, nf, nr, ff, lf, nps);
        chk("t1_fwd_cnt", nf, 992);
        chk("t1_last_fwd", lf, 'h400);
        chk("t1_rev_cnt", nr, 992);
        measure(1, -1, 0, nf, nr, ff, lf, nps);
        chk("t1_r_fwd_cnt", nf, 992);
        chk("t1_r_rev_cnt", nr, 992);
        chk("t1_pstrt_cnt", nps, 1);

        set_spd(-1024, 1023);
        measure(0, -1, 0, nf, nr, ff, lf, nps);
        measure(0, -1, 0, nf, nr, ff, lf, nps);
        chk("t2_min_fwd", nf, 0);
        chk("t2_min_rev", nr, 2048);
        measure(1, -1, 0, nf, nr, ff, lf, nps);
        chk("t2_max_fwd", nf, 2015);
        chk("t2_max_rev", nr, 0);
        chk("t2_max_first", ff, 33);

        set_spd(0, 0);
        measure(0, -1, 0, nf, nr, ff, lf, nps);
        measure(0, 'h200, 'h100, nf, nr, ff, lf, nps);
        chk("t3_old_last", lf, 'h400);
        chk("t3_old_cnt", nf, 992);
        measure(0, -1, 0, nf, nr, ff, lf, nps);
        chk("t3_new_first", ff, 33);
        chk("t3_new_last", lf, 'h500);
        chk("t3_new_cnt", nf, 1248);

        set_spd(500, -500);
        measure(0, -1, 0, nf, nr, ff, lf, nps);
        measure(0, -1, 0, nf, nr, ff, lf, nps);
        chk("t6_l_fwd", nf, 1492);
        chk("t6_l_rev", nr, 492);
        chk("t6_l_last", lf, 'h5F4);
        measure(1, -1, 0, nf, nr, ff, lf, nps);
        chk("t6_r_fwd", nf, 492);
        chk("t6_r_rev", nr, 1492);
        chk("t6_r_last", lf, 'h20C);
        chk("t6_pstrt_cnt", nps, 1);

        // Reset mid-period while driving forward.
        set_spd(0, 0);
        measure(0, -1, 0, nf, nr, ff, lf, nps);
        wait_pstrt();
        repeat ('h300) @(negedge clk);
        #2;
        chk("t5_fwd_before", int'(lft_fwd), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_async_out", int'({lft_fwd, lft_rev, rght_fwd, rght_rev}), 0);
        chk("t5_async_cnt", int'(period_strt), 1);
        tick(3);
        rst_n = 1'b1;
        ps0 = 1'b0;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (k == 0) ps0 = period_strt;
            if (lft_fwd | lft_rev | rght_fwd | rght_rev) break;
        end
        chk("t5_first_rise", k, 33);
        chk("t5_pstrt_after", int'(ps0), 1);
        $display("reset release: first drive edge after %0d clks", k);

        // Randomized segments with one asynchronous reset in the middle.
        for (int s = 0; s < 40; s++) begin
            set_spd(rand_spd(), rand_spd());
            $display("segment %0d: lft_spd=%0d rght_spd=%0d", s, lft_spd, rght_spd);
            tick($urandom_range(20, 700));
            if (s == 20) begin
                #($urandom_range(0, 2));
                rst_n = 1'b0;
                #1;
                chk("rand_async_out", int'({lft_fwd, lft_rev, rght_fwd, rght_rev}), 0);
                tick($urandom_range(1, 3));
                rst_n = 1'b1;
            end
        end
        tick(2100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
